// File: rtl/clkdiv_if.sv
// Tap-select / divided-count bundle between the clock divider and its users.
interface clkdiv_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 5
);
  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] clkdiv;
  logic             tick;

  modport master (output sel, input clkdiv, input tick);
  modport slave  (input sel, output clkdiv, output tick);
endinterface

// File: rtl/clkdiv.sv
// Free-running binary divider; bit k is clk/2^(k+1). tick strobes on a rising
// edge of the selected counter bit so consumers can use clock enables.
module clkdiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  clkdiv_if.slave  bus
);

  // Rise vector is zero-extended to the full tap range so out-of-range taps read 0.
  localparam int unsigned TAPS = 2 ** SEL_W;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rise;
  logic [TAPS-1:0]  rise_ext;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d    = cnt_q + WIDTH'(1);
    rise     = cnt_d & ~cnt_q;
    rise_ext = TAPS'(rise);
    tick_d   = rise_ext[bus.sel];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  // Count bits feed clock pins downstream, so they come straight off flops.
  assign bus.clkdiv = cnt_q;
  assign bus.tick   = tick_q;

endmodule

// File: tb/tb_clkdiv.sv
// Bench for clkdiv: 32-bit and 8-bit instances checked against an edge-count model.
module tb_clkdiv;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  clkdiv_if #(.WIDTH(32), .SEL_W(5)) a_if ();
  clkdiv_if #(.WIDTH(8),  .SEL_W(5)) b_if ();

  clkdiv #(.WIDTH(32), .SEL_W(5)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  clkdiv #(.WIDTH(8),  .SEL_W(5)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: count of rising edges since reset, plus the tap seen at the last edge.
  longint n_m  = 0;
  int     sa_m = 0;
  int     sb_m = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) n_m <= 0;
    else begin
      n_m  <= n_m + 1;
      sa_m <= int'(a_if.sel);
      sb_m <= int'(b_if.sel);
    end
  end

  // Tick is due when the count modulo 2^(s+1) sits exactly at 2^s.
  function automatic logic exp_tick(input longint n, input int s, input int w);
    longint v, half;
    if (s >= w) return 1'b0;
    v    = n % (longint'(1) << w);
    half = longint'(1) << s;
    return ((v % (half * 2)) == half);
  endfunction

  always @(negedge clk) begin
    chk("a_cnt",  64'(a_if.clkdiv), 64'(n_m) & 64'hFFFF_FFFF);
    chk("a_tick", 64'(a_if.tick),   64'(exp_tick(n_m, sa_m, 32)));
    chk("b_cnt",  64'(b_if.clkdiv), 64'(n_m) & 64'hFF);
    chk("b_tick", 64'(b_if.tick),   64'(exp_tick(n_m, sb_m, 8)));
  end

  task automatic edge_n(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0, t1, t3, nt, at;
    logic [31:0] prev;
    a_if.sel = 5'd1;
    b_if.sel = 5'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_cnt",  64'(a_if.clkdiv), 0);
    chk("rst_a_tick", 64'(a_if.tick),   0);
    chk("rst_b_cnt",  64'(b_if.clkdiv), 0);
    #1 rst = 1'b1;

    edge_n(1); chk("cnt1", 64'(a_if.clkdiv), 1);
    edge_n(1); chk("cnt2", 64'(a_if.clkdiv), 2);
               chk("tick_sel1_at2", 64'(a_if.tick), 1);
    edge_n(1); chk("cnt3", 64'(a_if.clkdiv), 3);
               chk("tick_sel1_at3", 64'(a_if.tick), 0);
    edge_n(34); chk("cnt37", 64'(a_if.clkdiv), 37);

    // Asynchronous reset between edges.
    #1 rst = 1'b0;
    #1;
    chk("async_a_cnt",  64'(a_if.clkdiv), 0);
    chk("async_a_tick", 64'(a_if.tick),   0);
    chk("async_b_cnt",  64'(b_if.clkdiv), 0);
    #1 rst = 1'b1;
    edge_n(1); chk("resume1", 64'(a_if.clkdiv), 1);
    edge_n(1); chk("resume2", 64'(a_if.clkdiv), 2);
    edge_n(3); chk("resume5", 64'(a_if.clkdiv), 5);

    // Tap change 1 -> 2 at count 5.
    #1 a_if.sel = 5'd2;
    edge_n(1); chk("selchg_cnt6",  64'(a_if.clkdiv), 6);
               chk("selchg_tick6", 64'(a_if.tick), 0);
    edge_n(4); chk("selchg_tick10", 64'(a_if.tick), 0);
    edge_n(2); chk("selchg_cnt12",  64'(a_if.clkdiv), 12);
               chk("selchg_tick12", 64'(a_if.tick), 1);
    edge_n(8); chk("selchg_tick20", 64'(a_if.tick), 1);
    edge_n(80); chk("cnt100", 64'(a_if.clkdiv), 100);

    // Divided bits over 64 cycles.
    t0 = 0; t1 = 0; t3 = 0;
    prev = a_if.clkdiv;
    for (int i = 0; i < 64; i++) begin
      edge_n(1);
      if (a_if.clkdiv[0] != prev[0]) t0++;
      if (a_if.clkdiv[1] != prev[1]) t1++;
      if (a_if.clkdiv[3] != prev[3]) t3++;
      prev = a_if.clkdiv;
    end
    chk("toggles_bit0", 64'(t0), 64);
    chk("toggles_bit1", 64'(t1), 32);
    chk("toggles_bit3", 64'(t3), 8);

    #1 a_if.sel = 5'd0;
    nt = 0;
    for (int i = 0; i < 16; i++) begin
      edge_n(1);
      if (a_if.tick) begin
        nt++;
        chk("sel0_odd", 64'(a_if.clkdiv[0]), 1);
      end
    end
    chk("sel0_count", 64'(nt), 8);

    #1 a_if.sel = 5'd4;
    nt = 0;
    for (int i = 0; i < 64; i++) begin
      edge_n(1);
      if (a_if.tick) begin
        nt++;
        chk("sel4_phase", 64'(a_if.clkdiv % 32), 16);
      end
    end
    chk("sel4_count", 64'(nt), 2);

    // 8-bit wrap for every tap, including out-of-range taps.
    for (int s = 0; s < 10; s++) begin
      #1 b_if.sel = 5'(s);
      for (int i = 0; i < 300; i++) begin
        if (b_if.clkdiv == 8'd254) break;
        edge_n(1);
      end
      chk("wrap_reach254", 64'(b_if.clkdiv), 254);
      edge_n(1); chk("wrap_255", 64'(b_if.clkdiv), 255);
      edge_n(1); chk("wrap_0",   64'(b_if.clkdiv), 0);
                 chk("wrap_tick", 64'(b_if.tick), 0);
      edge_n(1); chk("wrap_1",   64'(b_if.clkdiv), 1);
    end

    #1 b_if.sel = 5'd7;
    nt = 0; at = -1;
    for (int i = 0; i < 256; i++) begin
      edge_n(1);
      if (b_if.tick) begin nt++; at = int'(b_if.clkdiv); end
    end
    chk("sel7_count", 64'(nt), 1);
    chk("sel7_at",    64'(at), 128);

    #1 b_if.sel = 5'd9;
    nt = 0;
    for (int i = 0; i < 256; i++) begin
      edge_n(1);
      if (b_if.tick) nt++;
    end
    chk("sel9_count", 64'(nt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
